// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared segment type, active-low glyph constants and hex decode helper
package hex_display_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      4'hF: return SEG_F;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: value/control inputs and segment outputs of the display scanner
import hex_display_pkg::*;

interface hex_display_scanner_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    blank_leading_zeros;
  logic [NUM_DIGITS-1:0]   blink_mask;
  seg_t                    seven_segment_out;
  logic [NUM_DIGITS-1:0]   digit_select_out;
  logic [7*NUM_DIGITS-1:0] static_segments_out;
  modport master(
    output value_in, load, blank_leading_zeros, blink_mask,
    input  seven_segment_out, digit_select_out, static_segments_out
  );
  modport slave(
    input  value_in, load, blank_leading_zeros, blink_mask,
    output seven_segment_out, digit_select_out, static_segments_out
  );
endinterface

// File: rtl/hex_digit_decoder.sv
// hex_digit_decoder: one nibble to active-low segments, forced blank on request
import hex_display_pkg::*;

module hex_digit_decoder (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output seg_t       seg_o
);
  // blanking overrides the glyph
  always_comb seg_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: shadowed hex value, static decode bus and multiplexed digit scan with blink
import hex_display_pkg::*;

module hex_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input logic clk,
  input logic reset,
  hex_display_scanner_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("hex_display_scanner: illegal NUM_DIGITS/SCAN_DIV/BLINK_DIV");
  end

  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [SW-1:0]           scan_q, scan_d;
  logic [BW-1:0]           blink_q, blink_d;
  logic                    phase_q, phase_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7*NUM_DIGITS-1:0] static_q, static_d;
  seg_t                    seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [NUM_DIGITS-1:0]   zero_hi, blank;
  logic                    scan_tc, blink_tc;

  // a digit is zero-blanked only when it and every digit above it are zero; digit 0 never is
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign zero_hi[k] = shadow_q[4*NUM_DIGITS-1:4*k] == '0;
    assign blank[k]   = (bus.blank_leading_zeros && k != 0 && zero_hi[k]) || (!phase_q && bus.blink_mask[k]);
    hex_digit_decoder u_dec (
      .nibble_i(shadow_q[4*k +: 4]),
      .blank_i (blank[k]),
      .seg_o   (static_d[7*k +: 7])
    );
  end

  // scan and blink dividers; the digit index steps on scan terminal count
  always_comb begin
    scan_tc  = scan_q == SW'(SCAN_DIV - 1);
    blink_tc = blink_q == BW'(BLINK_DIV - 1);
    scan_d   = scan_tc ? '0 : scan_q + 1'b1;
    blink_d  = blink_tc ? '0 : blink_q + 1'b1;
    phase_d  = phase_q ^ blink_tc;
    idx_d    = !scan_tc ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
  end

  // state and output registers; the mux takes its slice from the same decode as the static bus
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      scan_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
      idx_q    <= '0;
      static_q <= '1;
      seg_q    <= SEG_BLANK;
      sel_q    <= '1;
    end else begin
      if (bus.load) shadow_q <= bus.value_in;
      scan_q   <= scan_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      static_q <= static_d;
      seg_q    <= static_d[7*idx_q +: 7];
      sel_q    <= ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  assign bus.static_segments_out = static_q;
  assign bus.seven_segment_out   = seg_q;
  assign bus.digit_select_out    = sel_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: scoreboard bench against a time-based reference of the scanner
module tb_hex_display_scanner;
  localparam int ND = 4;

  typedef struct packed {
    logic [7*ND-1:0] st;
    logic [6:0]      seg;
    logic [ND-1:0]   sel;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] sh;
  int   t;
  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  hex_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, act, exp, t);
    end
  endtask

  // expected outputs after edge t: digit index and blink phase follow from elapsed cycles
  function automatic exp_t model();
    exp_t e;
    int   idx = ((t - 1) / 4) % ND;
    bit   on  = (((t - 1) / 16) % 2) == 0;
    for (int k = 0; k < ND; k++) begin
      logic [6:0] s = tab[sh[4*k +: 4]];
      if (bus.blank_leading_zeros && k > 0 && (sh >> (4*k)) == 16'h0) s = 7'h7F;
      else if (!on && bus.blink_mask[k]) s = 7'h7F;
      e.st[7*k +: 7] = s;
    end
    e.seg = e.st[7*idx +: 7];
    e.sel = ~(4'b0001 << idx);
    return e;
  endfunction

  task automatic cyc();
    exp_t e, g;
    if (reset) begin
      e  = '1;
      sh = '0;
      t  = 0;
    end else begin
      t++;
      e = model();
      if (bus.load) sh = bus.value_in;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("static", 32'(bus.static_segments_out), 32'(g.st));
    check("seg",    32'(bus.seven_segment_out),   32'(g.seg));
    check("sel",    32'(bus.digit_select_out),    32'(g.sel));
  endtask

  task automatic load_val(input logic [15:0] v);
    bus.value_in = v;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    bus.value_in = '0;
    bus.load = 1'b0;
    bus.blank_leading_zeros = 1'b0;
    bus.blink_mask = '0;
    sh = '0;
    t = 0;
    repeat (2) cyc();
    check("rst_sel", 32'(bus.digit_select_out), 32'hF);
    check("rst_static", 32'(bus.static_segments_out), 32'hFFF_FFFF);
    reset = 1'b0;
    cyc();
    check("first_sel", 32'(bus.digit_select_out), 32'hE);
    check("first_seg", 32'(bus.seven_segment_out), 32'h40);

    load_val(16'h12AF);
    check("load_12AF", 32'(bus.static_segments_out), 32'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
    repeat (20) cyc();

    bus.blank_leading_zeros = 1'b1;
    load_val(16'h00A0);
    check("blz_00A0", 32'(bus.static_segments_out), 32'({7'h7F, 7'h7F, 7'b0001000, 7'b1000000}));
    load_val(16'h0000);
    check("blz_0000", 32'(bus.static_segments_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));
    bus.blank_leading_zeros = 1'b0;

    bus.blink_mask = 4'b0001;
    load_val(16'h1234);
    repeat (40) cyc();
    bus.blink_mask = '0;

    for (int i = 0; i < 12; i++) begin
      bus.value_in = 16'($urandom);
      bus.load = 1'b1;
      cyc();
    end
    bus.load = 1'b0;

    for (int i = 0; i < 16 && bus.digit_select_out !== 4'b1011; i++) cyc();
    check("find_d2", 32'(bus.digit_select_out), 32'hB);
    reset = 1'b1;
    cyc();
    check("midrst_seg", 32'(bus.seven_segment_out), 32'h7F);
    reset = 1'b0;
    cyc();
    check("restart_sel", 32'(bus.digit_select_out), 32'hE);
    check("restart_seg", 32'(bus.seven_segment_out), 32'h40);
    for (int i = 0; i < 8; i++) begin
      bus.value_in = 16'($urandom);
      cyc();
    end

    for (int i = 0; i < 80; i++) begin
      bus.value_in = 16'($urandom) & {4{($urandom_range(0, 1) == 1) ? 4'hF : 4'h0}};
      bus.load = ($urandom_range(0, 3) == 0);
      bus.blank_leading_zeros = 1'($urandom);
      bus.blink_mask = 4'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 SHALL have parameters: NUM_DIGITS, default 4, digit count (legal 1..8); SCAN_DIV, default 50000, clk cycles each digit is held in scan (legal >= 2); BLINK_DIV, default 12500000, clk cycles per blink half-period (legal >= 2).
REQ-002 SHALL have ports:
  - clk  in  1  sole clock, all state on rising edge.
  - reset  in  1  synchronous, active-high.
  - value_in  in  4*NUM_DIGITS  hex value; nibble k = digit k, digit 0 least significant.
  - load  in  1  capture value_in into shadow register.
  - blank_leading_zeros  in  1  suppress leading zero digits.
  - blink_mask  in  NUM_DIGITS  bit k set = digit k blinks.
  - seven_segment_out  out  7  multiplexed segments of the currently selected digit, active-low.
  - digit_select_out  out  NUM_DIGITS  one-cold digit enable.
  - static_segments_out  out  7*NUM_DIGITS  all digits in parallel, active-low, slice k = digit k.

Function
REQ-003 SHALL use active-low encoding (bit 6 = g ... bit 0 = a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blank=1111111.
REQ-004 SHALL never drive X on any output; every unmatched decode path yields blank.
REQ-005 SHALL register value_in into the shadow register on any clk edge where load=1; with load=0 the shadow register holds and value_in is ignored.
REQ-006 SHALL register all outputs; a load in cycle N SHALL appear on static_segments_out in cycle N+2.
REQ-007 SHALL run a scan counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index advances k -> k+1, with NUM_DIGITS-1 wrapping to 0.
REQ-008 digit_select_out SHALL have exactly bit k low for the current index; seven_segment_out SHALL carry slice k of the static bus in the same cycle.
REQ-009 SHALL run a blink counter 0..BLINK_DIV-1 toggling blink_phase at terminal count; while blink_phase=off, digits with blink_mask bit set SHALL show blank.
REQ-010 With blank_leading_zeros=1, every digit above the most significant nonzero nibble SHALL be blank; digit 0 SHALL never be zero-blanked (value 0 shows a single '0').
REQ-011 Blanking SHALL be applied in this priority: zero blanking, then blink blanking, then hex decode.
REQ-012 If load coincides with scan terminal count, the advance and the capture SHALL both take effect; the new digit shows the new value from N+2.
REQ-013 blink_mask and blank_leading_zeros SHALL be sampled unregistered into the decode stage (1-cycle effect latency).
REQ-014 For NUM_DIGITS=1, the digit index SHALL stay 0 and digit_select_out SHALL be constant 0 after reset.

Reset
REQ-015 reset=1 SHALL, on the next edge, clear the shadow register, scan counter, digit index and blink counter, set blink_phase=on, and force seven_segment_out=1111111, digit_select_out=all ones, and static_segments_out=all ones.
REQ-016 A reset asserted mid-scan SHALL restart the scan at digit 0 in the first cycle after reset deasserts, with display value 0.

Structure
REQ-017 SHALL place the segment encoding constants, SEG_BLANK, and the 7-bit segment typedef in shared package hex_display_pkg.
REQ-018 SHALL instantiate NUM_DIGITS copies of a combinational sub-module hex_digit_decoder (nibble + blank -> segments).
REQ-019 SHALL size the counters with $clog2 of their parameter and SHALL reject illegal parameters at elaboration.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=16)
REQ-020 Reset, then load 16'h12AF at cycle N -> at N+2, static_segments_out slices 3..0 = 1111001, 0100100, 0001000, 0001110.
REQ-021 Free run -> digit_select_out cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles, with seven_segment_out matching the selected slice.
REQ-022 blank_leading_zeros=1, load 16'h00A0 -> slices 3..0 = blank, blank, 0001000, 1000000; then load 16'h0000 -> only slice 0 = 1000000.
REQ-023 blink_mask=4'b0001, value 16'h1234 -> slice 0 alternates 0011001 and blank every 16 cycles; slices 3..1 stay steady.
REQ-024 Assert reset for 1 cycle while digit 2 is selected -> outputs blank and all-ones, then the scan restarts at digit 0 showing '0'; with load=0, changing value_in leaves the outputs unchanged.
